bg_scroll_fetch: RTL



---
 rtl/bg_scroll_fetch.sv | 60 ++++++
 1 files changed

// File: rtl/bg_scroll_fetch.sv
// bg_scroll_fetch: 4x-upscaled, horizontally scrolling background ROM fetch with 2-cycle latency.
// Optional BG_DIM_EN adds a `dim` input that halves each RGB565 field of valid pixels.
module bg_scroll_fetch #(
  parameter int IMG_W    = 160,
  parameter int IMG_H    = 120,
  parameter int SCALE_SH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  pix_x,
  input  logic [8:0]  pix_y,
  input  logic        pix_valid,
  input  logic        frame_start,
  input  logic        scroll_en,
  input  logic [3:0]  scroll_step,
`ifdef BG_DIM_EN
  input  logic        dim,
`endif
  output logic [14:0] rom_addr,
  input  logic [15:0] rom_data,
  output logic [15:0] pix_out,
  output logic        pix_out_valid,
  output logic [7:0]  scroll_off
);
  logic [7:0]  u;
  logic [6:0]  v;
  logic [8:0]  c_sum, c;
  logic [8:0]  s_sum, s_next;
  logic        in_ok, s1_valid;
  logic [15:0] pix_d;
  always_comb begin
    u      = 8'(pix_x >> SCALE_SH);
    v      = 7'(pix_y >> SCALE_SH);
    c_sum  = {1'b0, u} + {1'b0, scroll_off};
    c      = (c_sum >= 9'(IMG_W)) ? c_sum - 9'(IMG_W) : c_sum;
    in_ok  = pix_valid && (pix_x < 10'(IMG_W << SCALE_SH)) && (pix_y < 9'(IMG_H << SCALE_SH));
    s_sum  = {1'b0, scroll_off} + {5'd0, scroll_step};
    s_next = (s_sum >= 9'(IMG_W)) ? s_sum - 9'(IMG_W) : s_sum;
`ifdef BG_DIM_EN
    pix_d  = dim ? {1'b0, rom_data[15:12], 1'b0, rom_data[10:6], 1'b0, rom_data[4:1]} : rom_data;
`else
    pix_d  = rom_data;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr      <= '0;
      s1_valid      <= 1'b0;
      pix_out       <= '0;
      pix_out_valid <= 1'b0;
      scroll_off    <= '0;
    end else begin
      if (in_ok) rom_addr <= 15'(v) * 15'(IMG_W) + 15'(c);
      s1_valid      <= in_ok;
      pix_out       <= s1_valid ? pix_d : 16'h0000;
      pix_out_valid <= s1_valid;
      if (frame_start && scroll_en) scroll_off <= s_next[7:0];
    end
  end
endmodule
